// File: rtl/membus_pkg.sv
// Shared types and defaults for the MMU bypass-path SRAM responder.
package membus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int DEF_MEM_AW      = 20;
    localparam int DEF_WAIT_STATES = 2;

endpackage

// File: rtl/membus_arbiter.sv
// Picks the instruction or data side for the next SRAM access.
// MEMBUS_RR_EN selects round-robin; otherwise data has fixed priority.
module membus_arbiter (
`ifdef MEMBUS_RR_EN
    input  logic clk,
    input  logic srst,
    input  logic take,
`endif
    input  logic ireq,
    input  logic dreq,
    output logic any_req,
    output logic gnt_d
);

    assign any_req = ireq | dreq;

`ifdef MEMBUS_RR_EN
    // Reset state means "instruction side was served last", so data wins the first tie.
    logic last_d_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            last_d_reg <= 1'b0;
        end else if (take) begin
            last_d_reg <= gnt_d;
        end
    end

    assign gnt_d = dreq & (~ireq | ~last_d_reg);
`else
    assign gnt_d = dreq;
`endif

endmodule

// File: rtl/membus_responder.sv
// Arbitrates MMU ifetch/data bypass requests onto one synchronous SRAM port with wait states.
// Define MEMBUS_RR_EN for round-robin arbitration instead of data-over-instruction priority.
module membus_responder
    import membus_pkg::*;
#(
    parameter int MEM_AW      = DEF_MEM_AW,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ireq_i,
    input  logic [31:0]       iaddr_i,
    output logic              iready_o,
    output logic [31:0]       idata_o,
    input  logic              dreq_i,
    input  logic [31:0]       daddr_i,
    input  logic              dwr_i,
    input  logic [3:0]        dbytesel_i,
    input  logic [31:0]       dwdata_i,
    output logic              dready_o,
    output logic [31:0]       drdata_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t     state_reg;
    logic [3:0] wait_reg;
    grant_t     gnt_reg;
    logic       wr_reg;
    logic       any_req;
    logic       gnt_d;
    logic [3:0] dbe_next;
    logic       unused_addr_bits;

    // Address bits above the SRAM window alias; byte offset is not used by a word SRAM.
    assign unused_addr_bits = ^{iaddr_i[31:MEM_AW+2], iaddr_i[1:0],
                                daddr_i[31:MEM_AW+2], daddr_i[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            assign dbe_next[gi] = ~dwr_i | dbytesel_i[gi];
        end
    endgenerate

`ifdef MEMBUS_RR_EN
    logic take;
    assign take = (state_reg == ST_IDLE) && any_req;
`endif

    membus_arbiter u_arb (
`ifdef MEMBUS_RR_EN
        .clk     (clk_i),
        .srst    (rst_i),
        .take    (take),
`endif
        .ireq    (ireq_i),
        .dreq    (dreq_i),
        .any_req (any_req),
        .gnt_d   (gnt_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            wait_reg    <= 4'd0;
            gnt_reg     <= GNT_I;
            wr_reg      <= 1'b0;
            iready_o    <= 1'b0;
            idata_o     <= 32'd0;
            dready_o    <= 1'b0;
            drdata_o    <= 32'd0;
            mem_ce_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'd0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        state_reg <= ST_ACCESS;
                        wait_reg  <= WAIT_LOAD;
                        mem_ce_o  <= 1'b1;
                        if (gnt_d) begin
                            gnt_reg     <= GNT_D;
                            wr_reg      <= dwr_i;
                            mem_we_o    <= dwr_i;
                            mem_be_o    <= dbe_next;
                            mem_addr_o  <= daddr_i[MEM_AW+1:2];
                            mem_wdata_o <= dwdata_i;
                        end else begin
                            gnt_reg    <= GNT_I;
                            wr_reg     <= 1'b0;
                            mem_we_o   <= 1'b0;
                            mem_be_o   <= 4'hF;
                            mem_addr_o <= iaddr_i[MEM_AW+1:2];
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wait_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                        mem_ce_o  <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (gnt_reg == GNT_D) begin
                            dready_o <= 1'b1;
                            if (!wr_reg) begin
                                drdata_o <= mem_rdata_i;
                            end
                        end else begin
                            iready_o <= 1'b1;
                            idata_o  <= mem_rdata_i;
                        end
                    end else begin
                        wait_reg <= wait_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Requester still holds the old request here; it is deliberately not sampled.
                    iready_o  <= 1'b0;
                    dready_o  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_responder.sv
// Directed bench for membus_responder: a WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
module tb_membus_responder;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load;
    logic        ireq, iready, dreq, dwr, dready;
    logic [31:0] iaddr, idata, daddr, dwdata, drdata;
    logic [3:0]  dbytesel;
    logic        mem_ce, mem_we;
    logic [3:0]  mem_be;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        ireq0, iready0, dreq0, dwr0, dready0;
    logic [31:0] iaddr0, idata0, daddr0, dwdata0, drdata0;
    logic [3:0]  dbytesel0;
    logic        mem_ce0, mem_we0;
    logic [3:0]  mem_be0;
    logic [19:0] mem_addr0;
    logic [31:0] mem_wdata0, mem_rdata0;

    logic [31:0] sram  [0:255];
    logic [31:0] sram0 [0:255];

    int n_vec = 0;
    int n_bad = 0;
    int overlap = 0;
    logic [31:0] last_drd = 32'd0;

    membus_responder #(.MEM_AW(20), .WAIT_STATES(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .ireq_i(ireq), .iaddr_i(iaddr), .iready_o(iready), .idata_o(idata),
        .dreq_i(dreq), .daddr_i(daddr), .dwr_i(dwr), .dbytesel_i(dbytesel), .dwdata_i(dwdata),
        .dready_o(dready), .drdata_o(drdata),
        .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    membus_responder #(.MEM_AW(20), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .ireq_i(ireq0), .iaddr_i(iaddr0), .iready_o(iready0), .idata_o(idata0),
        .dreq_i(dreq0), .daddr_i(daddr0), .dwr_i(dwr0), .dbytesel_i(dbytesel0), .dwdata_i(dwdata0),
        .dready_o(dready0), .drdata_o(drdata0),
        .mem_ce_o(mem_ce0), .mem_we_o(mem_we0), .mem_be_o(mem_be0), .mem_addr_o(mem_addr0),
        .mem_wdata_o(mem_wdata0), .mem_rdata_i(mem_rdata0)
    );

    // SRAM models: combinational read of the presented address, byte-lane writes on the edge.
    assign mem_rdata  = sram[mem_addr[7:0]];
    assign mem_rdata0 = sram0[mem_addr0[7:0]];

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 256; k++) sram[k] <= 32'd0;
            sram[1]  <= 32'h0BAD_F00D;
            sram[4]  <= 32'hDEAD_BEEF;
            sram[8]  <= 32'h1111_1111;
            sram[64] <= 32'hCAFE_0000;
        end else if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 256; k++) sram0[k] <= 32'd0;
            sram0[3] <= 32'h5A5A_0003;
        end else if (mem_ce0 && mem_we0) begin
            for (int b = 0; b < 4; b++)
                if (mem_be0[b]) sram0[mem_addr0[7:0]][8*b +: 8] <= mem_wdata0[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        if ((iready && dready) || (iready0 && dready0)) overlap++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_drd = 32'd0;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int          lat, ce_cnt;
        bit          got, other;
        logic [19:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] rd;
        lat = 0; ce_cnt = 0; got = 0; other = 0; a = '0; be = '0; we = 0; rd = '0;
        @(negedge clk);
        if (v.is_d) begin
            dreq = 1'b1; daddr = v.addr; dwr = v.wr; dbytesel = v.be; dwdata = v.wd;
        end else begin
            ireq = 1'b1; iaddr = v.addr;
        end
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_ce) begin
                ce_cnt++; a = mem_addr; be = mem_be; we = mem_we;
            end
            if (v.is_d ? dready : iready) begin
                got = 1; rd = v.is_d ? drdata : idata; other = v.is_d ? iready : dready;
            end
        end
        ireq = 1'b0; dreq = 1'b0; dwr = 1'b0;
        $display("txn %0d: %s %s addr=%h mem_addr=%h lat=%0d data=%h", idx,
                 v.is_d ? "D" : "I", v.wr ? "WR" : "RD", v.addr, a, lat, rd);
        chk("latency", lat, 4);
        chk("ce_cycles", ce_cnt, 3);
        chk("mem_addr", {12'd0, a}, {12'd0, v.exp_addr});
        chk("mem_be", {28'd0, be}, {28'd0, v.exp_be});
        chk("mem_we", {31'd0, we}, {31'd0, v.wr});
        chk("other_ready", {31'd0, other}, 32'd0);
        if (v.wr) begin
            chk("drdata_hold", rd, last_drd);
        end else begin
            chk("rdata", rd, v.exp_rd);
            if (v.is_d) last_drd = v.exp_rd;
        end
        @(negedge clk);
        chk("ready_pulse_end", {31'd0, iready | dready}, 32'd0);
    endtask

    vec_t vecs [7];
    int   cyc, got;
    int   t [0:4];
    bit   seq [0:3];
    logic [19:0] seen_addr;
    logic [31:0] seen_data;
    bit   exp_seq [0:3];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         20'd4,  4'hF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 4'h3, 32'h1234_5678, 20'd64, 4'h3, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0,         20'd64, 4'hF, 32'hCAFE_5678};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 20'd8,  4'h0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0,         20'd8,  4'hF, 32'h1111_1111};
        vecs[5] = '{1'b1, 1'b0, 32'hFFC0_0004, 4'h0, 32'h0,         20'd1,  4'hF, 32'h0BAD_F00D};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0100, 4'h0, 32'h0,         20'd64, 4'hF, 32'hCAFE_5678};
`ifdef MEMBUS_RR_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        rst = 1'b1; load = 1'b1;
        ireq = 0; iaddr = 0; dreq = 0; daddr = 0; dwr = 0; dbytesel = 0; dwdata = 0;
        ireq0 = 0; iaddr0 = 0; dreq0 = 0; daddr0 = 0; dwr0 = 0; dbytesel0 = 0; dwdata0 = 0;
        repeat (3) @(negedge clk);
        load = 1'b0; rst = 1'b0;

        chk("rst_ctrl", {24'd0, mem_ce, mem_we, mem_be, iready, dready}, 32'd0);
        chk("rst_addr", {12'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_idata", idata, 32'd0);
        chk("rst_drdata", drdata, 32'd0);
        chk("rst_ctrl0", {24'd0, mem_ce0, mem_we0, mem_be0, iready0, dready0}, 32'd0);

        // Reset held two cycles in the middle of a write access.
        @(negedge clk);
        dreq = 1'b1; daddr = 32'h0000_0040; dwr = 1'b1; dbytesel = 4'hF; dwdata = 32'h7777_7777;
        @(negedge clk);
        chk("mid_access_ce", {31'd0, mem_ce}, 32'd1);
        rst = 1'b1; dreq = 1'b0; dwr = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", {24'd0, mem_ce, mem_we, mem_be, iready, dready}, 32'd0);
        chk("midrst_addr", {12'd0, mem_addr}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (iready || dready || mem_ce) got++;
        end
        $display("txn reset-mid-access: activity after release=%0d", got);
        chk("midrst_no_ready", got, 0);
        last_drd = 32'd0;

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Both sides requesting continuously.
        do_reset();
        @(negedge clk);
        ireq = 1'b1; iaddr = 32'h0000_0010; dreq = 1'b1; daddr = 32'h0000_0100; dwr = 1'b0;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (dready || iready) begin
                seq[got] = dready; t[got] = cyc; got++;
            end
        end
        ireq = 1'b0; dreq = 1'b0;
        chk("arb_count", got, 4);
        chk("arb_first_lat", t[0], 4);
        for (int k = 0; k < 4; k++) begin
            $display("txn arb %0d: side=%s cycle=%0d", k, seq[k] ? "D" : "I", t[k]);
            chk("arb_grant", {31'd0, seq[k]}, {31'd0, exp_seq[k]});
            if (k > 0) chk("arb_gap", t[k] - t[k-1], 5);
        end

        // Zero wait states, data request held high.
        @(negedge clk);
        dreq0 = 1'b1; daddr0 = 32'h0000_000C; dwr0 = 1'b0;
        got = 0; cyc = 0;
        while (got < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (dready0) begin
                t[got] = cyc; got++;
            end
        end
        dreq0 = 1'b0;
        $display("txn ws0: pulses=%0d first=%0d data=%h", got, t[0], drdata0);
        chk("ws0_count", got, 5);
        chk("ws0_first_lat", t[0], 2);
        for (int k = 1; k < 5; k++) chk("ws0_gap", t[k] - t[k-1], 3);
        chk("ws0_data", drdata0, 32'h5A5A_0003);

        // Request dropped and address changed one cycle after acceptance; high address bits alias.
        @(negedge clk);
        dreq = 1'b1; daddr = 32'hFFC0_0004; dwr = 1'b0;
        @(negedge clk);
        dreq = 1'b0; daddr = 32'h0000_0020;
        got = 0; seen_addr = '0; seen_data = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_ce) seen_addr = mem_addr;
            if (dready) begin
                got++; seen_data = drdata;
            end
        end
        $display("txn drop: pulses=%0d mem_addr=%h data=%h", got, seen_addr, seen_data);
        chk("drop_pulses", got, 1);
        chk("drop_addr", {12'd0, seen_addr}, 32'd1);
        chk("drop_data", seen_data, 32'h0BAD_F00D);

        chk("no_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
